filter_pump_scheduler: RTL
==========================

FILTER_PUMP_SCHEDULER -- requirements
Module: filter_pump_scheduler

Interface
REQ-001 Parameter PWM_DUTY, default 8'd192, SHALL set pump PWM high-time in counts of a 256-count period.
REQ-002 Parameter TIMEOUT_CYCLES, default 32'd50_000_000, SHALL set the maximum cycles allowed in any pumping state (used only with REQ-026).
REQ-003 Port clk_fpga  input  1  SHALL be the single system clock; all logic on its rising edge.
REQ-004 Port reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 Port i_dados  input  4  SHALL carry the water-status word from the BitDogLab (0000 = water OK, nonzero = anomalous).
REQ-006 Port i_req  input  1  SHALL be the asynchronous 4-phase request from the BitDogLab.
REQ-007 Port o_ack  output  1  SHALL be the 4-phase acknowledge.
REQ-008 Ports i_boia_cheia, i_boia_vazia  input  1 each  SHALL be the asynchronous full and empty float switches (active-high).
REQ-009 Ports o_pwm_bomba_a, o_pwm_bomba_b  output  1 each  SHALL drive pump A (fill) and pump B (drain).
REQ-010 Port o_state  output  3  SHALL expose the FSM state encoding: IDLE=0, FILL=1, DRAIN=2, STOPPING=3, FAULT=4.
REQ-011 Port o_status  output  4  SHALL expose the last accepted status word.
REQ-012 Port o_fault  output  1  SHALL flag the FAULT state.

Function
REQ-013 i_req, i_boia_cheia and i_boia_vazia SHALL each pass through a 2-flop synchronizer before use.
REQ-014 When synchronized req=1 and o_ack=0, the block SHALL latch i_dados into o_status and set o_ack on the same edge; latency from i_req rise to o_ack rise is 3 cycles.
REQ-015 o_ack SHALL stay high until synchronized req=0, then clear on the next edge; no new word SHALL be accepted while o_ack=1.
REQ-016 In IDLE, the FSM SHALL go to FILL if status!=0 and full=0, go to DRAIN if status!=0 and full=1, and otherwise stay in IDLE.
REQ-017 In FILL, the FSM SHALL go to STOPPING if status==0; else go to DRAIN if full=1; else stay.
REQ-018 In DRAIN, the FSM SHALL go to STOPPING if status==0; else go to FILL if empty=1; else stay.
REQ-019 In STOPPING, the FSM SHALL go to IDLE if empty=1, regardless of new status words; else stay.
REQ-020 If full=1 and empty=1 simultaneously (sensor contradiction), the FSM SHALL hold its current state and both pumps SHALL be forced off for that cycle.
REQ-021 The pumps SHALL be mutually exclusive: pump A enabled only in FILL, pump B only in DRAIN and STOPPING; never both.
REQ-022 A free-running 8-bit counter SHALL wrap from 255 to 0; each enabled pump output SHALL be high when counter < PWM_DUTY.
REQ-023 PWM_DUTY=0 SHALL keep the outputs low; PWM_DUTY=255 SHALL give 255/256 high-time.
REQ-024 Pump outputs SHALL be registered and SHALL go low on the first edge after the state leaves the pump's enabling state.

Reset
REQ-025 Asserting reset (low), including mid-handshake or mid-pumping, SHALL immediately force: state=IDLE, o_ack=0, o_status=0, both PWM outputs=0, o_fault=0, PWM counter=0, synchronizers=0, timeout counter=0.

Configuration
REQ-026 With PUMP_TIMEOUT_EN defined, a counter SHALL clear on every state change and increment in FILL, DRAIN and STOPPING; reaching TIMEOUT_CYCLES SHALL enter FAULT.
REQ-027 FAULT SHALL force both pumps off and set o_fault=1, and SHALL be left only by reset; handshakes SHALL still be acknowledged and o_status updated while in FAULT.
REQ-028 Without PUMP_TIMEOUT_EN, the FAULT state and timeout counter SHALL not exist and o_fault SHALL be tied to 0.

Verification
REQ-029 Reset released, empty=1, full=0; send 0100 -> o_ack rises 3 cycles after i_req; o_status=0100; state FILL; only pump A toggles with duty 192/256.
REQ-030 In FILL, set full=1 -> state DRAIN within 3 cycles; pump A low, pump B PWM; then empty=1 with full=0 -> back to FILL.
REQ-031 In DRAIN, send 0000 -> STOPPING; send 0100 while in STOPPING -> still STOPPING; empty=1 -> IDLE; both pumps low.
REQ-032 In FILL, drive full=1 and empty=1 together -> state held and both pumps low; release empty -> DRAIN.
REQ-033 Assert reset while o_ack=1 and in DRAIN -> all outputs 0 and state IDLE immediately; a fresh handshake after release completes normally.
REQ-034 With PUMP_TIMEOUT_EN and TIMEOUT_CYCLES=100, stay in FILL for 100 cycles -> state FAULT, o_fault=1, pumps low; a later handshake is acknowledged but the state stays FAULT.

Source files
------------

// File: rtl/filter_pump_scheduler.sv
// Filter pump scheduler: 4-phase status handshake, fill/drain pump FSM, registered PWM pump drives.
// Optional watchdog: define PUMP_TIMEOUT_EN to add the FAULT state and the pumping-time counter.
module filter_pump_scheduler #(
    parameter logic [7:0]  PWM_DUTY       = 8'd192,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000
) (
    input  logic       clk_fpga,
    input  logic       reset,
    input  logic [3:0] i_dados,
    input  logic       i_req,
    output logic       o_ack,
    input  logic       i_boia_cheia,
    input  logic       i_boia_vazia,
    output logic       o_pwm_bomba_a,
    output logic       o_pwm_bomba_b,
    output logic [2:0] o_state,
    output logic [3:0] o_status,
    output logic       o_fault
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FILL     = 3'd1,
        S_DRAIN    = 3'd2,
        S_STOPPING = 3'd3
`ifdef PUMP_TIMEOUT_EN
        , S_FAULT  = 3'd4
`endif
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [1:0] req_sync;
    logic [1:0] full_sync;
    logic [1:0] empty_sync;
    logic [7:0] pwm_cnt;
    logic       req_s;
    logic       full_s;
    logic       empty_s;
    logic       conflict;
    logic       pumping;
    logic       pwm_on;

    assign req_s    = req_sync[1];
    assign full_s   = full_sync[1];
    assign empty_s  = empty_sync[1];
    assign conflict = full_s & empty_s;
    assign pumping  = (state == S_FILL) || (state == S_DRAIN) || (state == S_STOPPING);
    assign pwm_on   = (pwm_cnt < PWM_DUTY);
    assign o_state  = state;

    always_ff @(posedge clk_fpga or negedge reset) begin
        if (!reset) begin
            req_sync   <= 2'b00;
            full_sync  <= 2'b00;
            empty_sync <= 2'b00;
        end else begin
            req_sync   <= {req_sync[0], i_req};
            full_sync  <= {full_sync[0], i_boia_cheia};
            empty_sync <= {empty_sync[0], i_boia_vazia};
        end
    end

    // i_dados is sampled raw: the 4-phase protocol keeps it stable while req is high.
    always_ff @(posedge clk_fpga or negedge reset) begin
        if (!reset) begin
            o_ack    <= 1'b0;
            o_status <= 4'd0;
        end else if (req_s && !o_ack) begin
            o_ack    <= 1'b1;
            o_status <= i_dados;
        end else if (!req_s && o_ack) begin
            o_ack    <= 1'b0;
        end
    end

    always_ff @(posedge clk_fpga or negedge reset) begin
        if (!reset) begin
            pwm_cnt <= 8'd0;
        end else begin
            pwm_cnt <= pwm_cnt + 8'd1;
        end
    end

`ifdef PUMP_TIMEOUT_EN
    logic [31:0] tmo_cnt;
    logic        tmo_hit;

    assign tmo_hit = pumping && (tmo_cnt >= TIMEOUT_CYCLES - 32'd1);

    always_ff @(posedge clk_fpga or negedge reset) begin
        if (!reset) begin
            tmo_cnt <= 32'd0;
        end else if (next_state != state) begin
            tmo_cnt <= 32'd0;
        end else if (pumping) begin
            tmo_cnt <= tmo_cnt + 32'd1;
        end
    end

    assign o_fault = (state == S_FAULT);
`else
    logic tmo_hit;
    logic unused_timeout;

    // The timeout parameter stays in the interface so both builds share one instantiation.
    assign tmo_hit        = 1'b0;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign o_fault        = 1'b0;
`endif

    // A full/empty contradiction freezes the FSM; the watchdog still wins because FAULT is safe.
    always_comb begin
        next_state = state;
        if (!conflict) begin
            case (state)
                S_IDLE:     if (o_status != 4'd0) next_state = full_s ? S_DRAIN : S_FILL;
                S_FILL:     if (o_status == 4'd0) next_state = S_STOPPING;
                            else if (full_s)      next_state = S_DRAIN;
                S_DRAIN:    if (o_status == 4'd0) next_state = S_STOPPING;
                            else if (empty_s)     next_state = S_FILL;
                S_STOPPING: if (empty_s)          next_state = S_IDLE;
                default:                          next_state = state;
            endcase
        end
`ifdef PUMP_TIMEOUT_EN
        if (tmo_hit) next_state = S_FAULT;
`endif
    end

    always_ff @(posedge clk_fpga or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            o_pwm_bomba_a <= 1'b0;
            o_pwm_bomba_b <= 1'b0;
        end else begin
            state         <= next_state;
            o_pwm_bomba_a <= (state == S_FILL) && !conflict && !tmo_hit && pwm_on;
            o_pwm_bomba_b <= ((state == S_DRAIN) || (state == S_STOPPING)) && !conflict
                             && !tmo_hit && pwm_on;
        end
    end

endmodule
